// File: rtl/s2p3_pack.sv
// Serial-to-3-parallel packer: gathers three consecutive accepted samples into
// one block on x3k/x3k1/x3k2 with valid/ready handshakes on both sides.
module s2p3_pack #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic [DW-1:0] din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] x3k,
    output logic [DW-1:0] x3k1,
    output logic [DW-1:0] x3k2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] blk_cnt
);

    typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;

    phase_t        phase, phase_nx;
    logic [DW-1:0] hold0, hold1;
    logic          accept, deliver, load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= PH0;
        else     phase <= phase_nx;
    end

    // sync restarts the phase; a sample accepted alongside it becomes lane 0
    always_comb begin
        in_ready = !((phase == PH2) && out_valid && !out_ready);
        accept   = in_valid && in_ready;
        deliver  = out_valid && out_ready;
        load     = accept && (phase == PH2) && !sync;
        phase_nx = phase;
        if (sync) begin
            phase_nx = accept ? PH1 : PH0;
        end else if (accept) begin
            case (phase)
                PH0:     phase_nx = PH1;
                PH1:     phase_nx = PH2;
                default: phase_nx = PH0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0     <= '0;
            hold1     <= '0;
            x3k       <= '0;
            x3k1      <= '0;
            x3k2      <= '0;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            if (accept && (sync || phase == PH0)) hold0 <= din;
            else if (accept && phase == PH1)      hold1 <= din;

            if (load) begin
                x3k  <= hold0;
                x3k1 <= hold1;
                x3k2 <= din;
            end

            if (load)         out_valid <= 1'b1;
            else if (deliver) out_valid <= 1'b0;

            if (deliver) blk_cnt <= blk_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_s2p3_pack.sv
// Self-checking bench for s2p3_pack: directed scenarios plus random handshakes,
// compared against a sample-queue reference model.
module tb_s2p3_pack;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sync;
    logic [DW-1:0] din;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x3k, x3k1, x3k2;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] blk_cnt;

    int checks   = 0;
    int failures = 0;

    s2p3_pack #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x3k       (x3k),
        .x3k1      (x3k1),
        .x3k2      (x3k2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    // reference model: pending samples of the current block, output block, count
    logic [DW-1:0] part[$];
    logic [DW-1:0] m_out[3];
    logic          m_valid;
    int            m_blocks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        part.delete();
        m_valid  = 1'b0;
        m_blocks = 0;
        for (int unsigned i = 0; i < 3; i++) m_out[i] = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("blk_cnt", 32'(blk_cnt), 32'(m_blocks % (1 << CW)));
        if (m_valid) begin
            chk("x3k", 32'(x3k), 32'(m_out[0]));
            chk("x3k1", 32'(x3k1), 32'(m_out[1]));
            chk("x3k2", 32'(x3k2), 32'(m_out[2]));
        end
    endtask

    // called just after a falling edge: drive inputs, run one clock, check outputs
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic s);
        logic exp_rdy, acc, dlv, blk_done;
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        sync      = s;
        #1;
        // the final sample of a block waits only while a full block is stuck
        exp_rdy = !(part.size() == 2 && m_valid && !ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        dlv = m_valid && ordy;
        if (dlv) begin
            m_blocks++;
            m_valid = 1'b0;
        end
        if (s) part.delete();
        blk_done = 1'b0;
        if (acc) begin
            part.push_back(d);
            if (part.size() == 3) begin
                for (int unsigned i = 0; i < 3; i++) m_out[i] = part[i];
                part.delete();
                blk_done = 1'b1;
            end
        end
        if (blk_done) m_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_x3k", 32'(x3k), 32'd0);
        chk("rst_x3k1", 32'(x3k1), 32'd0);
        chk("rst_x3k2", 32'(x3k2), 32'd0);
        chk("rst_cnt", 32'(blk_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);
        chk("rel_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; din = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init_ready", 32'(in_ready), 32'd1);
        check_outputs();

        // plain stream, no backpressure
        for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        chk("s_x3k", 32'(x3k), 32'd4);
        chk("s_x3k2", 32'(x3k2), 32'd6);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("s_cnt", 32'(blk_cnt), 32'd2);

        // backpressure: third sample of the next block must wait
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("bp_x3k", 32'(x3k), 32'd1);
        step(1'b1, 16'd6, 1'b0, 1'b0);
        chk("bp_hold", 32'(x3k1), 32'd2);
        step(1'b1, 16'd6, 1'b1, 1'b0);
        chk("bp_new", 32'(x3k), 32'd4);
        chk("bp_cnt", 32'(blk_cnt), 32'd3);

        // sync drops the partial 7,8 and restarts with 9
        step(1'b1, 16'd7, 1'b1, 1'b0);
        step(1'b1, 16'd8, 1'b1, 1'b0);
        step(1'b1, 16'd9, 1'b1, 1'b1);
        step(1'b1, 16'd10, 1'b1, 1'b0);
        step(1'b1, 16'd11, 1'b1, 1'b0);
        chk("sy_x3k", 32'(x3k), 32'd9);
        chk("sy_x3k1", 32'(x3k1), 32'd10);
        chk("sy_x3k2", 32'(x3k2), 32'd11);

        // reset while a block is stalled and a partial is pending
        step(1'b1, 16'd12, 1'b0, 1'b0);
        async_reset();

        // counter wrap with CW=4: 17 deliveries
        for (int i = 0; i < 51; i++) step(1'b1, DW'(i + 100), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_cnt", 32'(blk_cnt), 32'd1);

        // random handshakes
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
